// File: rtl/demux2_pkg.sv
// Shared types and defaults for the 1:2 stream demultiplexer.
package demux2_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_CNT_W = 16;

  // Occupancy of a 2-entry channel buffer.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

endpackage

// File: rtl/demux2_stream_if.sv
// Stream bundle for demux2_stream: one valid/ready input, two valid/ready outputs.
// Counter outputs exist only when DEMUX2_CNT_EN is defined.
interface demux2_stream_if
  import demux2_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) ();

  logic [WIDTH-1:0] a_i;
  logic             valid_i;
  logic             sel_i;
  logic             ready_o;
  logic [WIDTH-1:0] y0_o;
  logic [WIDTH-1:0] y1_o;
  logic             y0_valid_o;
  logic             y1_valid_o;
  logic             y0_ready_i;
  logic             y1_ready_i;

  if (WIDTH < 1 || CNT_W < 1) begin : g_bad_params
    $error("demux2_stream_if: WIDTH and CNT_W must be at least 1");
  end

`ifdef DEMUX2_CNT_EN
  logic [CNT_W-1:0] cnt0_o;
  logic [CNT_W-1:0] cnt1_o;

  modport slave (
    input  a_i, valid_i, sel_i, y0_ready_i, y1_ready_i,
    output ready_o, y0_o, y1_o, y0_valid_o, y1_valid_o, cnt0_o, cnt1_o
  );

  modport master (
    output a_i, valid_i, sel_i, y0_ready_i, y1_ready_i,
    input  ready_o, y0_o, y1_o, y0_valid_o, y1_valid_o, cnt0_o, cnt1_o
  );
`else
  modport slave (
    input  a_i, valid_i, sel_i, y0_ready_i, y1_ready_i,
    output ready_o, y0_o, y1_o, y0_valid_o, y1_valid_o
  );

  modport master (
    output a_i, valid_i, sel_i, y0_ready_i, y1_ready_i,
    input  ready_o, y0_o, y1_o, y0_valid_o, y1_valid_o
  );
`endif

endinterface

// File: rtl/demux2_buf.sv
// 2-entry registered channel buffer. Head data, pop_valid and push_ready are
// all flops, so nothing passes combinationally from push side to pop side.
module demux2_buf
  import demux2_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] push_data,
  input  logic             push_valid,
  output logic             push_ready,
  output logic [WIDTH-1:0] pop_data,
  output logic             pop_valid,
  input  logic             pop_ready
);

  buf_state_t       state;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;
  logic             push;
  logic             pop;

  assign push     = push_valid && push_ready;
  assign pop      = pop_valid && pop_ready;
  assign pop_data = head;

  // Occupancy FSM with registered ready/valid; tail is only ever read into head.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= EMPTY;
      head       <= '0;
      tail       <= '0;
      pop_valid  <= 1'b0;
      push_ready <= 1'b1;
    end else begin
      unique case (state)
        EMPTY: begin
          if (push) begin
            head      <= push_data;
            state     <= ONE;
            pop_valid <= 1'b1;
          end
        end
        ONE: begin
          if (push && pop) begin
            head <= push_data;
          end else if (push) begin
            tail       <= push_data;
            state      <= FULL;
            push_ready <= 1'b0;
          end else if (pop) begin
            state     <= EMPTY;
            pop_valid <= 1'b0;
          end
        end
        FULL: begin
          if (pop) begin
            head       <= tail;
            state      <= ONE;
            push_ready <= 1'b1;
          end
        end
        default: begin
          state      <= EMPTY;
          pop_valid  <= 1'b0;
          push_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/demux2_stream.sv
// Registered 1:2 stream demultiplexer: sel_i steers each accepted word into
// channel 0 or channel 1, each with its own 2-entry buffer.
// Optional feature: define DEMUX2_CNT_EN for saturating per-channel
// delivered-word counters (cnt0_o / cnt1_o).
module demux2_stream
  import demux2_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input logic            clk,
  input logic            reset_n,
  demux2_stream_if.slave bus
);

  logic buf0_ready;
  logic buf1_ready;
  logic push0_valid;
  logic push1_valid;

  if (WIDTH < 1 || CNT_W < 1) begin : g_bad_params
    $error("demux2_stream: WIDTH and CNT_W must be at least 1");
  end

  // Only the selected buffer ever sees valid, so the other one is untouched.
  assign push0_valid = bus.valid_i && !bus.sel_i;
  assign push1_valid = bus.valid_i &&  bus.sel_i;
  assign bus.ready_o = bus.sel_i ? buf1_ready : buf0_ready;

  demux2_buf #(.WIDTH(WIDTH)) u_buf0 (
    .clk        (clk),
    .reset_n    (reset_n),
    .push_data  (bus.a_i),
    .push_valid (push0_valid),
    .push_ready (buf0_ready),
    .pop_data   (bus.y0_o),
    .pop_valid  (bus.y0_valid_o),
    .pop_ready  (bus.y0_ready_i)
  );

  demux2_buf #(.WIDTH(WIDTH)) u_buf1 (
    .clk        (clk),
    .reset_n    (reset_n),
    .push_data  (bus.a_i),
    .push_valid (push1_valid),
    .push_ready (buf1_ready),
    .pop_data   (bus.y1_o),
    .pop_valid  (bus.y1_valid_o),
    .pop_ready  (bus.y1_ready_i)
  );

`ifdef DEMUX2_CNT_EN
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  // Count output transfers per channel, holding at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (bus.y0_valid_o && bus.y0_ready_i && (cnt0 != '1)) cnt0 <= cnt0 + 1'b1;
      if (bus.y1_valid_o && bus.y1_ready_i && (cnt1 != '1)) cnt1 <= cnt1 + 1'b1;
    end
  end

  assign bus.cnt0_o = cnt0;
  assign bus.cnt1_o = cnt1;
`endif

endmodule

// File: tb/tb_demux2_stream.sv
// Scoreboard bench for demux2_stream: stimulus pushes expected words per
// channel, a negedge monitor pops and compares on every output transfer.
module tb_demux2_stream;
  import demux2_pkg::*;

  localparam int W  = 8;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset_n;

  demux2_stream_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  demux2_stream #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  int unsigned  vectors     = 0;
  int unsigned  miscompares = 0;
  logic [W-1:0] exp0[$];
  logic [W-1:0] exp1[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: each output transfer must match the head of that channel's queue.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (bus.y0_valid_o === 1'b1 && bus.y0_ready_i === 1'b1) begin
        if (exp0.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL ch0_unexpected: got 0x%0h, want no word (t=%0t)", bus.y0_o, $time);
        end else begin
          check("ch0_data", 32'(bus.y0_o), 32'(exp0.pop_front()));
        end
      end
      if (bus.y1_valid_o === 1'b1 && bus.y1_ready_i === 1'b1) begin
        if (exp1.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL ch1_unexpected: got 0x%0h, want no word (t=%0t)", bus.y1_o, $time);
        end else begin
          check("ch1_data", 32'(bus.y1_o), 32'(exp1.pop_front()));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] d, input logic s);
    bus.a_i     = d;
    bus.sel_i   = s;
    bus.valid_i = 1'b1;
    if (s) exp1.push_back(d);
    else   exp0.push_back(d);
  endtask

  // Hold the driven word until accepted; returns 1 time unit after the accept edge.
  task automatic wait_accept(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus.ready_o === 1'b1) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    check({name, "_accept"}, 32'(ok), 32'd1);
    if (!ok) begin
      if (bus.sel_i) void'(exp1.pop_back());
      else           void'(exp0.pop_back());
    end
    bus.valid_i = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] d, input logic s, input string name);
    drive(d, s);
    wait_accept(name);
  endtask

  // Wait (bounded) until the chosen channel's expected queue has drained.
  task automatic drain(input string name, input int ch);
    for (int i = 0; i < 60; i++) begin
      if ((ch == 0 ? exp0.size() : exp1.size()) == 0) break;
      @(posedge clk);
      #2;
    end
    check({name, "_drain"}, (ch == 0) ? 32'(exp0.size()) : 32'(exp1.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.a_i        = '0;
    bus.sel_i      = 1'b0;
    bus.valid_i    = 1'b0;
    bus.y0_ready_i = 1'b0;
    bus.y1_ready_i = 1'b0;
    reset_n        = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_y0_valid", 32'(bus.y0_valid_o), 32'd0);
    check("rst_y1_valid", 32'(bus.y1_valid_o), 32'd0);
    check("rst_y0_data",  32'(bus.y0_o), 32'd0);
    check("rst_y1_data",  32'(bus.y1_o), 32'd0);
    check("rst_ready_s0", 32'(bus.ready_o), 32'd1);
    bus.sel_i = 1'b1;
    #1;
    check("rst_ready_s1", 32'(bus.ready_o), 32'd1);
    bus.sel_i = 1'b0;
`ifdef DEMUX2_CNT_EN
    check("rst_cnt0", 32'(bus.cnt0_o), 32'd0);
    check("rst_cnt1", 32'(bus.cnt1_o), 32'd0);
`endif
    tick();
    reset_n = 1'b1;

    // Basic routing, one-cycle latency, valid for exactly one cycle
    bus.y0_ready_i = 1'b1;
    bus.y1_ready_i = 1'b1;
    tick();
    send(8'h11, 1'b0, "t1_w11");
    @(negedge clk);
    check("t1_y0_valid_lat", 32'(bus.y0_valid_o), 32'd1);
    check("t1_y0_data",      32'(bus.y0_o), 32'h11);
    @(negedge clk);
    check("t1_y0_valid_once", 32'(bus.y0_valid_o), 32'd0);
    tick();
    send(8'h22, 1'b1, "t1_w22");
    @(negedge clk);
    check("t1_y1_valid_lat", 32'(bus.y1_valid_o), 32'd1);
    check("t1_y1_data",      32'(bus.y1_o), 32'h22);
    @(negedge clk);
    check("t1_y1_valid_once", 32'(bus.y1_valid_o), 32'd0);

    // Back-pressure on ch0: two accepts then ready drops, head held stable
    tick();
    bus.y0_ready_i = 1'b0;
    send(8'hA0, 1'b0, "t3_a0");
    send(8'hA1, 1'b0, "t3_a1");
    drive(8'hA2, 1'b0);
    @(negedge clk);
    check("t3_ready_full", 32'(bus.ready_o), 32'd0);
    check("t3_y0_head",    32'(bus.y0_o), 32'hA0);
    check("t3_y0_valid",   32'(bus.y0_valid_o), 32'd1);
    @(negedge clk);
    check("t3_ready_still_full", 32'(bus.ready_o), 32'd0);
    check("t3_y0_held",          32'(bus.y0_o), 32'hA0);
    @(posedge clk);
    #1;
    bus.y0_ready_i = 1'b1;
    wait_accept("t3_a2");
    drain("t3", 0);

    // ch0 stalled full; ch1 streams 1 word/cycle unaffected
    tick();
    bus.y0_ready_i = 1'b0;
    send(8'hB0, 1'b0, "t4_b0");
    send(8'hB1, 1'b0, "t4_b1");
    bus.y1_ready_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(8'(i), 1'b1);
      @(negedge clk);
      check("t4_ready_s1", 32'(bus.ready_o), 32'd1);
      if (i > 1) check("t4_y1_valid", 32'(bus.y1_valid_o), 32'd1);
      @(posedge clk);
      #1;
    end
    bus.valid_i = 1'b0;
    drain("t4", 1);
    check("t4_y0_stalled_head",  32'(bus.y0_o), 32'hB0);
    check("t4_y0_stalled_valid", 32'(bus.y0_valid_o), 32'd1);

    // Asynchronous reset with both buffers full
    bus.y1_ready_i = 1'b0;
    tick();
    send(8'hC0, 1'b1, "t5_c0");
    send(8'hC1, 1'b1, "t5_c1");
    bus.sel_i = 1'b1;
    @(negedge clk);
    check("t5_ch1_full", 32'(bus.ready_o), 32'd0);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("t5_y0_valid_async", 32'(bus.y0_valid_o), 32'd0);
    check("t5_y1_valid_async", 32'(bus.y1_valid_o), 32'd0);
    check("t5_ready_s1",       32'(bus.ready_o), 32'd1);
    check("t5_y0_data",        32'(bus.y0_o), 32'd0);
    check("t5_y1_data",        32'(bus.y1_o), 32'd0);
    bus.sel_i = 1'b0;
    #1;
    check("t5_ready_s0", 32'(bus.ready_o), 32'd1);
    exp0.delete();
    exp1.delete();
    @(posedge clk);
    #1;
    reset_n        = 1'b1;
    bus.y0_ready_i = 1'b1;
    bus.y1_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t5_no_stale_y0", 32'(bus.y0_valid_o), 32'd0);
      check("t5_no_stale_y1", 32'(bus.y1_valid_o), 32'd0);
    end
`ifdef DEMUX2_CNT_EN
    check("t5_cnt0_cleared", 32'(bus.cnt0_o), 32'd0);
    check("t5_cnt1_cleared", 32'(bus.cnt1_o), 32'd0);

    // Counter saturation: 20 words on ch1 with a 4-bit counter
    tick();
    for (int i = 0; i < 20; i++) send(8'(8'h60 + i), 1'b1, "t7_word");
    drain("t7", 1);
    tick();
    check("t7_cnt1_sat", 32'(bus.cnt1_o), 32'd15);
    check("t7_cnt0_idle", 32'(bus.cnt0_o), 32'd0);
`endif

    // Simultaneous push and pop while holding one word
    tick();
    bus.y0_ready_i = 1'b0;
    send(8'h40, 1'b0, "t6_w40");
    @(negedge clk);
    check("t6_one_valid", 32'(bus.y0_valid_o), 32'd1);
    check("t6_one_head",  32'(bus.y0_o), 32'h40);
    check("t6_one_ready", 32'(bus.ready_o), 32'd1);
    @(posedge clk);
    #1;
    bus.y0_ready_i = 1'b1;
    drive(8'h5C, 1'b0);
    wait_accept("t6_w5c");
    @(negedge clk);
    check("t6_head_5c",  32'(bus.y0_o), 32'h5C);
    check("t6_valid_5c", 32'(bus.y0_valid_o), 32'd1);
    check("t6_ready_5c", 32'(bus.ready_o), 32'd1);
    @(negedge clk);
    check("t6_count_was_one", 32'(bus.y0_valid_o), 32'd0);
`ifdef DEMUX2_CNT_EN
    check("t6_cnt0", 32'(bus.cnt0_o), 32'd2);
`endif

    drain("final0", 0);
    drain("final1", 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
